// File: rtl/xgmii_rx_engine.sv
// XGMII receive engine: filters UDP/IPv4 frames for this host with a
// magic code, strips the headers and FCS, and writes the payload to a FIFO.
// Ports: xgmii_clk/sys_rst_n clock and reset; xgmii_rxd 72-bit XGMII word;
// if_v4addr/if_macaddr local addresses; fifo_din/fifo_wr_en/fifo_full FIFO
// write side; rx_good_cnt/rx_drop_cnt/rx_err_cnt frame statistics.
module xgmii_rx_engine #(
    parameter logic [31:0] MAGIC_CODE = 32'h0000_0000,
    parameter logic [15:0] UDP_PORT   = 16'd9,
    parameter logic [7:0]  MAX_WORDS  = 8'd255
) (
    input  logic        xgmii_clk,
    input  logic        sys_rst_n,
    input  logic [71:0] xgmii_rxd,
    input  logic [31:0] if_v4addr,
    input  logic [47:0] if_macaddr,
    output logic [71:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic [31:0] rx_good_cnt,
    output logic [31:0] rx_drop_cnt,
    output logic [31:0] rx_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_DROP,
        S_FLUSH
    } state_t;

    state_t      state_q;
    logic [7:0]  idx_q;
    logic        hdr_ok_q;
    logic [63:0] hold_q;
    logic        hold_v_q;
    logic [3:0]  flush_cnt_q;
    logic [71:0] din_q;
    logic        wr_en_q;
    logic [31:0] good_q;
    logic [31:0] drop_q;
    logic [31:0] err_q;

    logic [7:0]  ctrl;
    logic [63:0] data;
    logic        any_ctrl;
    logic [2:0]  first_lane;
    logic [7:0]  first_byte;
    logic        is_term;
    logic        has_term;
    logic        start_ok;
    logic        hdr_chk;

    assign ctrl = xgmii_rxd[71:64];
    assign data = xgmii_rxd[63:0];
    assign any_ctrl = |ctrl;
    assign start_ok = (ctrl == 8'h01) &&
                      (data == 64'hd555_5555_5555_55fb);

    // The lowest control lane decides whether a word ends cleanly;
    // idle bytes following a terminate are also control lanes.
    always_comb begin
        first_lane = 3'd0;
        first_byte = 8'h00;
        has_term   = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            if (ctrl[b]) begin
                first_lane = 3'(b);
                first_byte = data[8*b +: 8];
            end
        end
        for (int b = 0; b < 8; b++) begin
            if (ctrl[b] && data[8*b +: 8] == 8'hfd) begin
                has_term = 1'b1;
            end
        end
    end

    assign is_term = any_ctrl && (first_byte == 8'hfd);

    always_comb begin
        hdr_chk = 1'b1;
        case (idx_q)
            8'd1: hdr_chk = (data[7:0]   == if_macaddr[47:40]) &&
                            (data[15:8]  == if_macaddr[39:32]) &&
                            (data[23:16] == if_macaddr[31:24]) &&
                            (data[31:24] == if_macaddr[23:16]) &&
                            (data[39:32] == if_macaddr[15:8])  &&
                            (data[47:40] == if_macaddr[7:0]);
            8'd2: hdr_chk = (data[39:32] == 8'h08) &&
                            (data[47:40] == 8'h00) &&
                            (data[55:48] == 8'h45);
            8'd3: hdr_chk = (data[63:56] == 8'h11);
            8'd4: hdr_chk = (data[55:48] == if_v4addr[31:24]) &&
                            (data[63:56] == if_v4addr[23:16]);
            8'd5: hdr_chk = (data[7:0]   == if_v4addr[15:8]) &&
                            (data[15:8]  == if_v4addr[7:0])  &&
                            (data[39:32] == UDP_PORT[15:8])  &&
                            (data[47:40] == UDP_PORT[7:0]);
            8'd6: hdr_chk = (data[23:16] == MAGIC_CODE[31:24]) &&
                            (data[31:24] == MAGIC_CODE[23:16]) &&
                            (data[39:32] == MAGIC_CODE[15:8])  &&
                            (data[47:40] == MAGIC_CODE[7:0]);
            default: hdr_chk = 1'b1;
        endcase
    end

    always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 8'd0;
            hdr_ok_q    <= 1'b0;
            hold_q      <= 64'd0;
            hold_v_q    <= 1'b0;
            flush_cnt_q <= 4'd0;
            din_q       <= 72'd0;
            wr_en_q     <= 1'b0;
            good_q      <= 32'd0;
            drop_q      <= 32'd0;
            err_q       <= 32'd0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_q  <= S_HDR;
                        idx_q    <= 8'd1;
                        hdr_ok_q <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (any_ctrl) begin
                        if (is_term) begin
                            drop_q  <= drop_q + 32'd1;
                            state_q <= S_IDLE;
                        end else begin
                            err_q   <= err_q + 32'd1;
                            state_q <= has_term ? S_IDLE : S_DROP;
                        end
                    end else if (idx_q == 8'd6) begin
                        if (hdr_ok_q && hdr_chk && !fifo_full) begin
                            state_q  <= S_PAYLOAD;
                            idx_q    <= 8'd7;
                            hold_v_q <= 1'b0;
                        end else begin
                            drop_q  <= drop_q + 32'd1;
                            state_q <= S_DROP;
                        end
                    end else begin
                        hdr_ok_q <= hdr_ok_q && hdr_chk;
                        idx_q    <= idx_q + 8'd1;
                    end
                end
                S_PAYLOAD: begin
                    if (idx_q >= MAX_WORDS || (any_ctrl && !is_term)) begin
                        // Abort: close the frame with an error marker.
                        err_q    <= err_q + 32'd1;
                        hold_v_q <= 1'b0;
                        state_q  <= has_term ? S_IDLE : S_DROP;
                        if (hold_v_q && !fifo_full) begin
                            din_q   <= {4'b1100, 4'd8, hold_q};
                            wr_en_q <= 1'b1;
                        end
                    end else if (any_ctrl) begin
                        hold_v_q <= 1'b0;
                        state_q  <= S_IDLE;
                        if (idx_q == 8'd7 && first_lane <= 3'd4) begin
                            // Nothing left once the FCS is removed.
                            drop_q <= drop_q + 32'd1;
                        end else if (first_lane <= 3'd4) begin
                            if (fifo_full) begin
                                err_q <= err_q + 32'd1;
                            end else begin
                                din_q   <= {4'b1000,
                                            4'd4 + {1'b0, first_lane},
                                            hold_q};
                                wr_en_q <= 1'b1;
                                good_q  <= good_q + 32'd1;
                            end
                        end else if (hold_v_q && fifo_full) begin
                            err_q <= err_q + 32'd1;
                        end else begin
                            // Current word still has payload bytes;
                            // emit it on the following cycle.
                            if (hold_v_q) begin
                                din_q   <= {4'b0000, 4'd8, hold_q};
                                wr_en_q <= 1'b1;
                            end
                            hold_q      <= data;
                            flush_cnt_q <= {1'b0, first_lane} - 4'd4;
                            state_q     <= S_FLUSH;
                        end
                    end else begin
                        idx_q    <= idx_q + 8'd1;
                        hold_q   <= data;
                        hold_v_q <= 1'b1;
                        if (hold_v_q) begin
                            if (fifo_full) begin
                                err_q   <= err_q + 32'd1;
                                state_q <= S_DROP;
                            end else begin
                                din_q   <= {4'b0000, 4'd8, hold_q};
                                wr_en_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (has_term) begin
                        state_q <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (fifo_full) begin
                        err_q <= err_q + 32'd1;
                    end else begin
                        din_q   <= {4'b1000, flush_cnt_q, hold_q};
                        wr_en_q <= 1'b1;
                        good_q  <= good_q + 32'd1;
                    end
                    if (start_ok) begin
                        state_q  <= S_HDR;
                        idx_q    <= 8'd1;
                        hdr_ok_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fifo_din    = din_q;
    assign fifo_wr_en  = wr_en_q;
    assign rx_good_cnt = good_q;
    assign rx_drop_cnt = drop_q;
    assign rx_err_cnt  = err_q;

endmodule

// File: tb/tb_xgmii_rx_engine.sv
// Directed testbench for xgmii_rx_engine.
// Builds XGMII frames byte by byte and checks FIFO writes and counters.
module tb_xgmii_rx_engine;

    localparam logic [47:0] MAC   = 48'h00_11_22_33_44_55;
    localparam logic [31:0] IP    = 32'h0a_00_00_02;
    localparam logic [31:0] MAGIC = 32'h1234_5678;
    localparam logic [71:0] IDLE_W = {8'hff, 64'h0707_0707_0707_0707};

    logic        clk;
    logic        rst_n;
    logic [71:0] rxd;
    logic        full;
    logic [71:0] din;
    logic        wr;
    logic [31:0] good;
    logic [31:0] drop;
    logic [31:0] err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0]  wc[$];
    logic [63:0] wd[$];
    logic [71:0] cap_d[$];
    int          cap_c[$];

    xgmii_rx_engine #(
        .MAGIC_CODE(MAGIC)
    ) dut (
        .xgmii_clk  (clk),
        .sys_rst_n  (rst_n),
        .xgmii_rxd  (rxd),
        .if_v4addr  (IP),
        .if_macaddr (MAC),
        .fifo_din   (din),
        .fifo_wr_en (wr),
        .fifo_full  (full),
        .rx_good_cnt(good),
        .rx_drop_cnt(drop),
        .rx_err_cnt (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr === 1'b1) begin
            cap_d.push_back(din);
            cap_c.push_back(cyc);
        end
    end

    // tot = bytes after the preamble word, FCS included.
    task automatic build(input logic [47:0] mac, input logic [15:0] port,
                         input logic [31:0] magic, input int tot,
                         input int e_word, input int e_lane);
        logic [383:0] hdr;
        logic [7:0]   b[$];
        logic [7:0]   c;
        logic [63:0]  d;
        logic [7:0]   v;
        int           nw;
        int           k;
        hdr = {mac, 48'h02_00_00_00_00_01, 32'h0800_4500,
               16'h0032, 16'h0000, 16'h4000, 8'h40, 8'h11,
               16'h0000, 32'hc0a8_0001, IP, 16'h0400, port,
               16'h001c, 16'h0000, magic, 16'h0000};
        b = {};
        for (int i = 0; i < 48; i++) b.push_back(hdr[383-8*i -: 8]);
        for (int i = 48; i < tot; i++) begin
            v = (i < tot - 4) ? 8'(i - 48) : 8'hcc;
            b.push_back(v);
        end
        wc.delete();
        wd.delete();
        wc.push_back(8'h01);
        wd.push_back(64'hd555_5555_5555_55fb);
        nw = tot / 8 + 1;
        for (int w = 0; w < nw; w++) begin
            c = 8'h00;
            d = 64'd0;
            for (int l = 0; l < 8; l++) begin
                k = 8 * w + l;
                if (k < tot) begin
                    d[8*l +: 8] = b[k];
                end else begin
                    c[l] = 1'b1;
                    d[8*l +: 8] = (k == tot) ? 8'hfd : 8'h07;
                end
            end
            wc.push_back(c);
            wd.push_back(d);
        end
        if (e_word > 0) begin
            c = wc[e_word];
            d = wd[e_word];
            c[e_lane] = 1'b1;
            d[8*e_lane +: 8] = 8'hfe;
            wc[e_word] = c;
            wd[e_word] = d;
        end
    endtask

    task automatic send(input int full_from);
        cap_d.delete();
        cap_c.delete();
        for (int i = 0; i < wc.size(); i++) begin
            @(negedge clk);
            rxd  = {wc[i], wd[i]};
            full = (full_from >= 0 && i >= full_from);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rxd  = IDLE_W;
            full = 1'b0;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rxd   = IDLE_W;
        full  = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (din !== 72'd0 || wr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out din=%h wr=%b exp 0/0", din, wr);
        end
        n_chk++;
        if (good !== 0 || drop !== 0 || err !== 0) begin
            n_fail++;
            $display("FAIL reset_cnt got %0d/%0d/%0d exp 0/0/0",
                     good, drop, err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame;
        build(MAC, 16'd9, MAGIC, 68, 0, 0);
        send(-1);
        n_chk++;
        if (cap_d.size() !== 2) begin
            n_fail++;
            $display("FAIL good_nwr got %0d exp 2", cap_d.size());
        end
        if (cap_d.size() == 2) begin
            n_chk++;
            if (cap_d[0] !== {8'h08, 64'h0706_0504_0302_0100}) begin
                n_fail++;
                $display("FAIL good_w0 got %h exp %h", cap_d[0],
                         {8'h08, 64'h0706_0504_0302_0100});
            end
            n_chk++;
            if (cap_d[1] !== {8'h88, 64'h0f0e_0d0c_0b0a_0908}) begin
                n_fail++;
                $display("FAIL good_w1 got %h exp %h", cap_d[1],
                         {8'h88, 64'h0f0e_0d0c_0b0a_0908});
            end
            n_chk++;
            if (cap_c[1] - cap_c[0] !== 1) begin
                n_fail++;
                $display("FAIL good_gap got %0d exp 1",
                         cap_c[1] - cap_c[0]);
            end
        end
        n_chk++;
        if (good !== 32'd1) begin
            n_fail++;
            $display("FAIL good_cnt got %0d exp 1", good);
        end
    endtask

    task automatic test_odd_lengths;
        build(MAC, 16'd9, MAGIC, 70, 0, 0);
        send(-1);
        n_chk++;
        if (cap_d.size() !== 3) begin
            n_fail++;
            $display("FAIL lane6_nwr got %0d exp 3", cap_d.size());
        end
        if (cap_d.size() == 3) begin
            n_chk++;
            if (cap_d[1] !== {8'h08, 64'h0f0e_0d0c_0b0a_0908}) begin
                n_fail++;
                $display("FAIL lane6_w1 got %h", cap_d[1]);
            end
            n_chk++;
            if (cap_d[2][71:64] !== 8'h82 ||
                cap_d[2][15:0] !== 16'h1110) begin
                n_fail++;
                $display("FAIL lane6_w2 got %h exp 82/..1110", cap_d[2]);
            end
            n_chk++;
            if (cap_c[2] - cap_c[1] !== 1) begin
                n_fail++;
                $display("FAIL lane6_gap got %0d exp 1",
                         cap_c[2] - cap_c[1]);
            end
        end
        build(MAC, 16'd9, MAGIC, 65, 0, 0);
        send(-1);
        n_chk++;
        if (cap_d.size() !== 2) begin
            n_fail++;
            $display("FAIL lane1_nwr got %0d exp 2", cap_d.size());
        end
        if (cap_d.size() == 2) begin
            n_chk++;
            if (cap_d[0] !== {8'h08, 64'h0706_0504_0302_0100}) begin
                n_fail++;
                $display("FAIL lane1_w0 got %h", cap_d[0]);
            end
            n_chk++;
            if (cap_d[1][71:64] !== 8'h85 ||
                cap_d[1][39:0] !== 40'h0c_0b0a_0908) begin
                n_fail++;
                $display("FAIL lane1_w1 got %h exp 85/..0c0b0a0908",
                         cap_d[1]);
            end
        end
        n_chk++;
        if (good !== 32'd3) begin
            n_fail++;
            $display("FAIL odd_cnt got %0d exp 3", good);
        end
    endtask

    task automatic test_filter;
        build(48'h00_11_22_33_44_56, 16'd9, MAGIC, 68, 0, 0);
        send(-1);
        n_chk++;
        if (cap_d.size() !== 0) begin
            n_fail++;
            $display("FAIL flt_mac nwr got %0d exp 0", cap_d.size());
        end
        build(MAC, 16'd10, MAGIC, 68, 0, 0);
        send(-1);
        n_chk++;
        if (cap_d.size() !== 0) begin
            n_fail++;
            $display("FAIL flt_port nwr got %0d exp 0", cap_d.size());
        end
        build(MAC, 16'd9, 32'h1234_5679, 68, 0, 0);
        send(-1);
        n_chk++;
        if (cap_d.size() !== 0) begin
            n_fail++;
            $display("FAIL flt_magic nwr got %0d exp 0", cap_d.size());
        end
        n_chk++;
        if (drop !== 32'd3 || good !== 32'd3) begin
            n_fail++;
            $display("FAIL flt_cnt drop=%0d good=%0d exp 3/3", drop, good);
        end
    endtask

    task automatic test_abort;
        build(MAC, 16'd9, MAGIC, 68, 8, 3);
        send(-1);
        n_chk++;
        if (cap_d.size() !== 1) begin
            n_fail++;
            $display("FAIL abort_nwr got %0d exp 1", cap_d.size());
        end
        if (cap_d.size() == 1) begin
            n_chk++;
            if (cap_d[0] !== {8'hc8, 64'h0706_0504_0302_0100}) begin
                n_fail++;
                $display("FAIL abort_w0 got %h exp %h", cap_d[0],
                         {8'hc8, 64'h0706_0504_0302_0100});
            end
        end
        n_chk++;
        if (err !== 32'd1 || good !== 32'd3) begin
            n_fail++;
            $display("FAIL abort_cnt err=%0d good=%0d exp 1/3", err, good);
        end
        build(MAC, 16'd9, MAGIC, 68, 0, 0);
        send(-1);
        n_chk++;
        if (cap_d.size() !== 2 || good !== 32'd4) begin
            n_fail++;
            $display("FAIL abort_next nwr=%0d good=%0d exp 2/4",
                     cap_d.size(), good);
        end
    endtask

    task automatic test_overflow;
        build(MAC, 16'd9, MAGIC, 68, 0, 0);
        send(6);
        n_chk++;
        if (cap_d.size() !== 0 || drop !== 32'd4) begin
            n_fail++;
            $display("FAIL ovf_w6 nwr=%0d drop=%0d exp 0/4",
                     cap_d.size(), drop);
        end
        send(8);
        n_chk++;
        if (cap_d.size() !== 0) begin
            n_fail++;
            $display("FAIL ovf_w8 nwr got %0d exp 0", cap_d.size());
        end
        n_chk++;
        if (err !== 32'd2 || good !== 32'd4) begin
            n_fail++;
            $display("FAIL ovf_cnt err=%0d good=%0d exp 2/4", err, good);
        end
    endtask

    task automatic test_runt_and_reset;
        build(MAC, 16'd9, MAGIC, 51, 0, 0);
        send(-1);
        n_chk++;
        if (cap_d.size() !== 0 || drop !== 32'd5) begin
            n_fail++;
            $display("FAIL runt nwr=%0d drop=%0d exp 0/5",
                     cap_d.size(), drop);
        end
        build(MAC, 16'd9, MAGIC, 68, 0, 0);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            rxd  = {wc[i], wd[i]};
            full = 1'b0;
        end
        @(posedge clk);
        #2;
        n_chk++;
        if (wr !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre wr got %b exp 1", wr);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (din !== 72'd0 || wr !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async din=%h wr=%b exp 0/0", din, wr);
        end
        n_chk++;
        if (good !== 0 || drop !== 0 || err !== 0) begin
            n_fail++;
            $display("FAIL rst_cnt got %0d/%0d/%0d exp 0/0/0",
                     good, drop, err);
        end
        @(negedge clk);
        rxd = IDLE_W;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        build(MAC, 16'd9, MAGIC, 68, 0, 0);
        send(-1);
        n_chk++;
        if (cap_d.size() !== 2 || good !== 32'd1 || err !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_after nwr=%0d good=%0d err=%0d exp 2/1/0",
                     cap_d.size(), good, err);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_odd_lengths();
        test_filter();
        test_abort();
        test_overflow();
        test_runt_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xgmii_rx_engine.md
# xgmii_rx_engine

Receive-side counterpart of the XGMII transmit engine. It parses 72-bit XGMII receive words and filters UDP/IPv4 frames addressed to this interface that carry the project magic code. It strips the Ethernet/IP/UDP headers and the FCS, and pushes the payload into a 72-bit receive FIFO as byte-counted words. The PCIe side drains that FIFO.

## Interface
Parameters:
- MAGIC_CODE, 32'h0000_0000, required magic code; the top level overrides it with the project-wide `MAGIC_CODE` value.
- UDP_PORT, 16'd9, required UDP destination port.
- MAX_WORDS, 8'd255, frame length limit in XGMII words, counted from the start word.

Ports:
- xgmii_clk  in  1  single clock for all logic.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- xgmii_rxd  in  72  [71:64] per-lane control bits, [63:0] data; lane 0 is [7:0].
- if_v4addr  in  32  local IPv4 address.
- if_macaddr  in  48  local MAC address.
- fifo_din  out  72  [71] eof, [70] err, [69:68] zero, [67:64] valid byte count 1..8 (lanes 0..count-1), [63:0] payload.
- fifo_wr_en  out  1  one-cycle write strobe.
- fifo_full  in  1  FIFO full.
- rx_good_cnt  out  32  frames delivered with eof and no error.
- rx_drop_cnt  out  32  frames filtered out or runts.
- rx_err_cnt  out  32  aborted frames and lost FIFO writes.

## Operation
- Word index n is counted from the start word W0.
- W0 is valid only with ctrl 8'h01 and data 64'hd5555555555555fb. A start in lane 4, or any other start pattern, is ignored.
- Header checks; all must pass:
  - W1 bytes 0-5 = if_macaddr, with byte 0 = [47:40].
  - W2 bytes 4-5 = 08,00; W2 byte 6 = 45.
  - W3 byte 7 = 11.
  - W4 bytes 6-7 = if_v4addr[31:16], byte 6 high.
  - W5 bytes 0-1 = if_v4addr[15:0].
  - W5 bytes 4-5 = UDP_PORT, byte 4 high.
  - W6 bytes 2-5 = MAGIC_CODE, byte 2 = [31:24].
- The W6 checksum bytes and bytes 6-7 are discarded. Payload begins at W7 byte 0.
- States: IDLE, HDR (W1-W6), PAYLOAD, DROP (skip words until terminate), FLUSH (one cycle to emit a deferred partial word).
- IDLE -> HDR on a valid start.
- In HDR, any control bit in W1-W6 other than a terminate is an error: increment rx_err_cnt, go to DROP.
- In HDR, a terminate (0xfd) in W1-W6 is a runt: increment rx_drop_cnt, go to IDLE.
- A failed check or fifo_full at W6 sends the frame to DROP with rx_drop_cnt+1.
- One-word hold register for FCS stripping. A full data word Wn is written when W(n+1) arrives with ctrl 8'h00.
- Terminate at lane L of word Wn; payload bytes P = 8*(n-7)+L-4:
  - P<=0: no writes; rx_drop_cnt+1; go to IDLE.
  - L<4: the held word is written with count 4+L and eof.
  - L=4: the held word is written with count 8 and eof.
  - L>4: the held word is written with count 8; go to FLUSH; the next cycle writes the current word with count L-4 and eof.
- Each delivered frame increments rx_good_cnt.
- In PAYLOAD, /E/ (0xfe), an unexpected control byte, or word index reaching MAX_WORDS aborts the frame:
  - The held word is written with eof=1, err=1, and count 8.
  - rx_err_cnt+1; go to DROP, or to IDLE if the abort word was a terminate.
- A write required while fifo_full=1 is lost. rx_err_cnt+1. The frame goes to DROP with no eof.
- All counters wrap at 2^32.

## Timing
- Reset values: fifo_din=0, fifo_wr_en=0, all counters 0, state IDLE, hold register empty.
- Asynchronous assert; deassertion is used synchronously.
- All outputs are registered.
- A payload word sampled at edge k appears on fifo_din with fifo_wr_en=1 after edge k+1, when the next word is sampled.
- An eof for terminate lane <=4 appears after the terminate edge. For lane >4 it appears one edge later, from FLUSH.
- FLUSH always returns to IDLE. A start word sampled while in FLUSH is still recognized: FLUSH -> HDR.
- Counter updates are visible the cycle after the deciding edge.
- Reset mid-frame: everything returns to reset values; the partial frame is not completed.

## Test plan
- Good frame: 68-byte frame with matching MAC/IP/port/magic 32'h12345678; payload bytes 00..0f; terminate in W9 lane 4 -> two writes with counts 8 and 8, eof on the second, data 0706050403020100 and 0f0e0d0c0b0a0908; rx_good_cnt=1.
- Odd lengths: terminate in W9 lane 6 -> writes with counts 8, 8, 2 (last from FLUSH, eof). Terminate in W9 lane 1 -> writes with counts 8 and 5 (eof).
- Filter: wrong MAC, then wrong UDP port 10, then wrong magic -> no writes; rx_drop_cnt=3.
- Abort: 0xfe in W8 lane 3 -> W7 written with eof=1, err=1, count 8; rx_err_cnt=1. The next good frame is delivered normally.
- Overflow: fifo_full=1 at W6 -> drop, rx_drop_cnt+1. fifo_full=1 rising at W8 -> no write, rx_err_cnt+1, no eof.
- Runt and reset: terminate in W7 lane 3 -> no write, rx_drop_cnt+1. Assert sys_rst_n low at W8 -> all outputs 0 immediately, without a clock edge.
